// File: rtl/run_arb_pkg.sv
// Shared types and helpers for the run/done worker arbiter.
// State encodings are fixed so waveforms and debug tooling can decode them directly.
package run_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_WAIT = 2'b10,
    S_ACK  = 2'b11
  } state_e;

  localparam int TO_W_DEFAULT = 8;

  // Index width for a requester id; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request bit at or after ptr, wrapping
// circularly over N_REQ entries (N_REQ need not be a power of two).
module rr_picker
  import run_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             any,
  output logic [N_REQ-1:0] onehot,
  output logic [ID_W-1:0]  idx
);

  int              cand;
  logic [ID_W-1:0] cand_idx;

  // Walk the rotated order starting at ptr; the first hit is the winner.
  always_comb begin
    any      = 1'b0;
    onehot   = '0;
    idx      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = int'(ptr) + i;
      if (cand >= N_REQ) begin
        cand = cand - N_REQ;
      end
      cand_idx = ID_W'(cand);
      if (!any && req[cand_idx]) begin
        any              = 1'b1;
        idx              = cand_idx;
        onehot[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/run_arbiter.sv
// Round-robin arbiter sharing one single-shot run/done worker between N_REQ requesters.
// Issues a 1-cycle run pulse, waits for done or timeout, then acks the owner.
module run_arbiter
  import run_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = TO_W_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         i_req,
  output logic [N_REQ-1:0]         o_grant,
  output logic [$clog2(N_REQ)-1:0] o_grant_id,
  output logic [N_REQ-1:0]         o_ack,
  output logic                     o_timeout,
  output logic                     o_busy,
  output logic                     o_run,
  input  logic                     i_done
);

  localparam int ID_W = id_width(N_REQ);

  state_e           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [ID_W-1:0]  grant_id_q, grant_id_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [TO_W-1:0]  cnt_q, cnt_d;
  logic             flag_q, flag_d;

  logic             pick_any;
  logic [N_REQ-1:0] pick_onehot;
  logic [ID_W-1:0]  pick_idx;

  rr_picker #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_picker (
    .req    (i_req),
    .ptr    (ptr_q),
    .any    (pick_any),
    .onehot (pick_onehot),
    .idx    (pick_idx)
  );

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    flag_d     = flag_q;
    case (state_q)
      S_IDLE: begin
        if (pick_any) begin
          grant_d    = pick_onehot;
          grant_id_d = pick_idx;
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A done arriving on the final wait cycle still counts as a normal completion.
        if (i_done) begin
          flag_d  = 1'b0;
          state_d = S_ACK;
        end else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
          flag_d  = 1'b1;
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ACK: begin
        ptr_d      = (grant_id_q == ID_W'(N_REQ - 1)) ? '0 : grant_id_q + 1'b1;
        grant_d    = '0;
        grant_id_d = '0;
        flag_d     = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      flag_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      flag_q     <= flag_d;
    end
  end

  // Moore outputs: grant registers are cleared on the way back to idle, so they read 0 there.
  assign o_run      = (state_q == S_RUN);
  assign o_busy     = (state_q != S_IDLE);
  assign o_grant    = grant_q;
  assign o_grant_id = grant_id_q;
  assign o_ack      = (state_q == S_ACK) ? grant_q : '0;
  assign o_timeout  = (state_q == S_ACK) && flag_q;

endmodule

// File: tb/tb_run_arbiter.sv
// Self-checking bench for run_arbiter: directed scenarios plus randomized operations,
// checked against an operation-level reference model (circular pick + done/timeout timing).
module tb_run_arbiter;

   localparam int NREQ = 4;
   localparam int TMO  = 5;

   logic        clk;
   logic        reset;
   logic [3:0]  iReq;
   logic [3:0]  oGrant;
   logic [1:0]  oGrantId;
   logic [3:0]  oAck;
   logic        oTimeout;
   logic        oBusy;
   logic        oRun;
   logic        iDone;

   int checkCount = 0;
   int passCount  = 0;
   int cycle      = 0;
   int refPtr     = 0;
   int lastRunCycle = 0;
   int lastGrantId  = 0;

   run_arbiter #(
      .N_REQ   (NREQ),
      .TIMEOUT (TMO),
      .TO_W    (8)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .i_req      (iReq),
      .o_grant    (oGrant),
      .o_grant_id (oGrantId),
      .o_ack      (oAck),
      .o_timeout  (oTimeout),
      .o_busy     (oBusy),
      .o_run      (oRun),
      .i_done     (iDone)
   );

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, observed, expected, cycle);
      end
   endtask

   // Advance to just after the next rising edge, where outputs are stable.
   task automatic step();
      @(posedge clk);
      #1;
      cycle++;
   endtask

   // Reference pick: first requester at or after the pointer, scanning circularly.
   function automatic int refPick(input logic [3:0] req, input int ptr);
      int idx;
      for (int i = 0; i < NREQ; i++) begin
         idx = (ptr + i) % NREQ;
         if (req[idx]) return idx;
      end
      return -1;
   endfunction

   // Checks that the arbiter is sitting idle with every output low.
   task automatic checkIdle(input string tag);
      checkOutput({tag, ".busy"},  32'(oBusy),    32'd0);
      checkOutput({tag, ".grant"}, 32'(oGrant),   32'd0);
      checkOutput({tag, ".id"},    32'(oGrantId), 32'd0);
      checkOutput({tag, ".ack"},   32'(oAck),     32'd0);
      checkOutput({tag, ".run"},   32'(oRun),     32'd0);
   endtask

   // One full operation starting from an idle cycle. doneDelay is the worker's answer
   // delay after o_run (0 = never answers). The model predicts grant, ack cycle and flag.
   task automatic applyStimulus(input logic [3:0] req, input int doneDelay, input bit dropReq,
                                input bit strayDone, input bit holdReq);
      int         g;
      int         ackOff;
      bit         answered;
      logic [3:0] gOne;
      g        = refPick(req, refPtr);
      gOne     = 4'(1 << g);
      answered = (doneDelay >= 1) && (doneDelay <= TMO);
      ackOff   = answered ? doneDelay + 1 : TMO + 1;

      iReq  = req;
      iDone = strayDone;
      step();
      lastRunCycle = cycle;
      lastGrantId  = int'(oGrantId);
      checkOutput("run.pulse", 32'(oRun),     32'd1);
      checkOutput("run.grant", 32'(oGrant),   32'(gOne));
      checkOutput("run.id",    32'(oGrantId), 32'(g));
      checkOutput("run.busy",  32'(oBusy),    32'd1);
      checkOutput("run.ack",   32'(oAck),     32'd0);
      iDone = strayDone;
      if (dropReq) iReq = req & ~gOne;

      for (int k = 1; k <= ackOff; k++) begin
         step();
         if (k < ackOff) begin
            iDone = (k == doneDelay);
            checkOutput("wait.ack",   32'(oAck),   32'd0);
            checkOutput("wait.run",   32'(oRun),   32'd0);
            checkOutput("wait.grant", 32'(oGrant), 32'(gOne));
         end else begin
            iDone = strayDone;
            checkOutput("ack.owner",   32'(oAck),     32'(gOne));
            checkOutput("ack.timeout", 32'(oTimeout), 32'(!answered));
            checkOutput("ack.busy",    32'(oBusy),    32'd1);
         end
      end

      refPtr = (g + 1) % NREQ;
      iReq   = holdReq ? req : 4'b0000;
      step();
      checkIdle("post");
      iDone = 1'b0;
   endtask

   initial begin
      int runCycles[5];
      int expOrder[5];
      logic [3:0] rReq;
      expOrder[0] = 0; expOrder[1] = 1; expOrder[2] = 2; expOrder[3] = 3; expOrder[4] = 0;

      reset = 1'b1;
      iReq  = 4'b0000;
      iDone = 1'b0;
      #1;
      checkIdle("reset");
      checkOutput("reset.timeout", 32'(oTimeout), 32'd0);
      step();
      step();
      reset = 1'b0;
      step();
      checkIdle("afterReset");

      // All requesters held: strict rotation, 5-cycle op spacing, acks only to owners.
      $display("[TB] rotation with all requests held");
      for (int i = 0; i < 5; i++) begin
         applyStimulus(4'b1111, 2, 1'b0, 1'b0, (i < 4));
         runCycles[i] = lastRunCycle;
         checkOutput("rr.order", 32'(lastGrantId), 32'(expOrder[i]));
         if (i > 0) checkOutput("rr.spacing", 32'(runCycles[i] - runCycles[i-1]), 32'd5);
      end

      // Single requester, then wrap-around from pointer 3.
      $display("[TB] single request and pointer wrap");
      applyStimulus(4'b0100, 2, 1'b0, 1'b0, 1'b0);
      checkOutput("single.id", 32'(lastGrantId), 32'd2);
      applyStimulus(4'b0011, 2, 1'b0, 1'b0, 1'b0);
      checkOutput("wrap.id0", 32'(lastGrantId), 32'd0);
      applyStimulus(4'b0011, 2, 1'b0, 1'b0, 1'b0);
      checkOutput("wrap.id1", 32'(lastGrantId), 32'd1);

      // Silent worker forces a timeout; done on the last wait cycle still wins.
      $display("[TB] timeout and last-cycle done");
      applyStimulus(4'b0010, 0, 1'b0, 1'b0, 1'b0);
      applyStimulus(4'b0010, TMO, 1'b0, 1'b1, 1'b0);

      // Stray done while idle with nobody requesting must not start or ack anything.
      iDone = 1'b1;
      step();
      iDone = 1'b0;
      checkIdle("strayIdle");

      // Randomized operations against the model.
      $display("[TB] randomized operations");
      for (int n = 0; n < 40; n++) begin
         rReq = 4'($urandom_range(1, 15));
         applyStimulus(rReq, int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'b0);
      end

      // Reset asserted between edges mid-wait clears everything without a clock edge.
      $display("[TB] asynchronous reset mid-operation");
      iReq = 4'b0001;
      step();
      checkOutput("midReset.run", 32'(oRun), 32'd1);
      step();
      step();
      #2;
      reset = 1'b1;
      #1;
      checkIdle("midReset");
      checkOutput("midReset.timeout", 32'(oTimeout), 32'd0);
      iReq = 4'b0000;
      step();
      reset = 1'b0;
      refPtr = 0;
      applyStimulus(4'b1000, 2, 1'b0, 1'b0, 1'b0);
      checkOutput("afterReset.id", 32'(lastGrantId), 32'd3);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
